// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_WIDTH     = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } opT;

endpackage

// File: rtl/multdiv_if.sv
// Operand/result bundle between the D/X register side and the multiply/divide unit.
interface multdiv_if #(
  parameter int WIDTH = multdiv_pkg::DEFAULT_WIDTH
);

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/dffe_ref.sv
// Single-bit flop with synchronous clear and load enable.
module dffe_ref (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_counter.sv
// Iteration counter built from dffe_ref bits; flags the final algorithm step.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int LIMIT = DEFAULT_WIDTH,
  parameter int CW    = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CW-1:0] count;
  logic [CW-1:0] countNext;

  assign countNext = clear ? '0 : count + CW'(1);

  for (genvar i = 0; i < CW; i++) begin : gBit
    dffe_ref uFf (
      .clk (clk),
      .clr (reset),
      .en  (clear | enable),
      .d   (countNext[i]),
      .q   (count[i])
    );
  end

  assign terminal = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) on operand magnitudes,
// with sign correction applied on the final step.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  multdiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  stateT            state;
  opT               op;
  opT               startOp;
  logic             negResult;
  logic [WIDTH-1:0] acc, lo, mag;
  logic [WIDTH-1:0] magA, magB;
  logic             accept, lastStep;

  logic [WIDTH:0]     sum, shifted, trial;
  logic [WIDTH-1:0]   nextAcc, nextLo, quotient;
  logic [2*WIDTH-1:0] product, signedProduct;
  logic               mulExc, divExc;

  assign accept  = (bus.ctrl_MULT | bus.ctrl_DIV) && (state != RUN);
  assign startOp = bus.ctrl_MULT ? OP_MULT : OP_DIV;
  assign magA    = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign magB    = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  multdiv_counter #(.LIMIT(WIDTH), .CW(CW)) uCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .enable   (state == RUN),
    .terminal (lastStep)
  );

  // acc/lo form one double-width register: {hi, multiplier} or {remainder, quotient}.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    sum     = '0;
    shifted = '0;
    trial   = '0;
    nextAcc = acc;
    nextLo  = lo;
    if (op == OP_MULT) begin
      sum     = {1'b0, acc} + (lo[0] ? {1'b0, mag} : '0);
      nextAcc = sum[WIDTH:1];
      nextLo  = {sum[0], lo[WIDTH-1:1]};
    end else begin
      shifted = {acc, lo[WIDTH-1]};
      trial   = shifted - {1'b0, mag};
      nextAcc = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      nextLo  = {lo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  assign product       = {nextAcc, nextLo};
  assign signedProduct = negResult ? -product : product;
  assign quotient      = negResult ? -nextLo : nextLo;
  // Overflow when the sign bit of the low half disagrees with any upper bit.
  assign mulExc = (|signedProduct[2*WIDTH-1:WIDTH-1]) && !(&signedProduct[2*WIDTH-1:WIDTH-1]);
  assign divExc = !negResult && nextLo[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      op                 <= OP_MULT;
      negResult          <= 1'b0;
      acc                <= '0;
      lo                 <= '0;
      mag                <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            op        <= startOp;
            negResult <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            acc       <= '0;
            lo        <= (startOp == OP_MULT) ? magB : magA;
            mag       <= (startOp == OP_MULT) ? magA : magB;
            if (startOp == OP_DIV && bus.data_operandB == '0) begin
              state              <= DONE;
              bus.data_result    <= '0;
              bus.data_exception <= 1'b1;
              bus.data_resultRDY <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= nextAcc;
          lo  <= nextLo;
          if (lastStep) begin
            state              <= DONE;
            bus.busy           <= 1'b0;
            bus.data_resultRDY <= 1'b1;
            bus.data_result    <= (op == OP_MULT) ? signedProduct[WIDTH-1:0] : quotient;
            bus.data_exception <= (op == OP_MULT) ? mulExc : divExc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: results, exceptions, busy/ready timing, reset abort, back-to-back.
module tb_multdiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          lat;
    int          busyCnt;
    logic        busyAtRdy;
    logic [31:0] res;
    logic        exc;
    logic        rdyAfter;
    logic        busyAfter;
  } obsT;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vecT;

  // Drives one start pulse and observes the op; returns one negedge after the ready cycle.
  task automatic doOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                      output obsT o);
    o.lat = -1; o.busyCnt = 0; o.busyAtRdy = 1'b0; o.res = '0; o.exc = 1'b0;
    @(negedge clk);
    bus.ctrl_MULT = m; bus.ctrl_DIV = d; bus.data_operandA = a; bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) begin
        o.lat = k; o.busyAtRdy = bus.busy; o.res = bus.data_result; o.exc = bus.data_exception;
        break;
      end
      if (bus.busy === 1'b1) o.busyCnt++;
      @(negedge clk);
    end
    @(negedge clk);
    o.rdyAfter  = bus.data_resultRDY;
    o.busyAfter = bus.busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.data_result !== 32'h0) begin errors++; $display("FAIL reset result got %h want 0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL reset exception got %b want 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset rdy got %b want 0", bus.data_resultRDY); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", bus.busy); end
  endtask

  task automatic test_table(input string name, input logic isMult, input vecT v[5]);
    obsT o;
    for (int i = 0; i < 5; i++) begin
      doOp(isMult, !isMult, v[i].a, v[i].b, o);
      checks++; if (o.res !== v[i].res) begin errors++; $display("FAIL %s[%0d] result got %h want %h", name, i, o.res, v[i].res); end
      checks++; if (o.exc !== v[i].exc) begin errors++; $display("FAIL %s[%0d] exception got %b want %b", name, i, o.exc, v[i].exc); end
      checks++; if (o.lat != 32) begin errors++; $display("FAIL %s[%0d] latency got %0d want 32", name, i, o.lat); end
      checks++; if (o.busyCnt != 32) begin errors++; $display("FAIL %s[%0d] busy cycles got %0d want 32", name, i, o.busyCnt); end
      checks++; if (o.busyAtRdy !== 1'b0) begin errors++; $display("FAIL %s[%0d] busy in rdy cycle got %b want 0", name, i, o.busyAtRdy); end
      checks++; if (o.rdyAfter !== 1'b0) begin errors++; $display("FAIL %s[%0d] rdy width got %b after want 0", name, i, o.rdyAfter); end
    end
  endtask

  task automatic test_mult();
    vecT v[5];
    v[0] = '{32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    v[1] = '{32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
    v[2] = '{32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
    v[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    v[4] = '{32'h4000_0000,  32'd2,         32'h8000_0000, 1'b1};
    test_table("mult", 1'b1, v);
  endtask

  task automatic test_div();
    vecT v[5];
    v[0] = '{32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    v[1] = '{32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    v[2] = '{32'd100,        32'd7,         32'd14,        1'b0};
    v[3] = '{32'd7,          32'hFFFF_FF9C, 32'd0,         1'b0};
    v[4] = '{32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0};
    test_table("div", 1'b0, v);
  endtask

  task automatic test_div_zero();
    obsT o;
    doOp(1'b0, 1'b1, 32'd5, 32'd0, o);
    checks++; if (o.lat != 0) begin errors++; $display("FAIL divzero latency got %0d want 0", o.lat); end
    checks++; if (o.res !== 32'h0) begin errors++; $display("FAIL divzero result got %h want 0", o.res); end
    checks++; if (o.exc !== 1'b1) begin errors++; $display("FAIL divzero exception got %b want 1", o.exc); end
    checks++; if (o.busyAtRdy !== 1'b0 || o.busyAfter !== 1'b0) begin errors++; $display("FAIL divzero busy got %b/%b want 0/0", o.busyAtRdy, o.busyAfter); end
    checks++; if (o.rdyAfter !== 1'b0) begin errors++; $display("FAIL divzero rdy width got %b after want 0", o.rdyAfter); end
  endtask

  task automatic test_simultaneous();
    obsT o;
    doOp(1'b1, 1'b1, 32'd3, 32'd2, o);
    checks++; if (o.res !== 32'd6) begin errors++; $display("FAIL both_ctrl result got %h want 6", o.res); end
    checks++; if (o.lat != 32) begin errors++; $display("FAIL both_ctrl latency got %0d want 32", o.lat); end
  endtask

  task automatic test_ignored_start();
    int          rdyCount = 0;
    int          rdyK = -1;
    logic [31:0] res = '0;
    @(negedge clk);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd7; bus.data_operandB = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (k == 10) begin
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd100; bus.data_operandB = 32'd5;
      end else if (k == 11) begin
        bus.ctrl_DIV = 1'b0;
      end
      if (bus.data_resultRDY === 1'b1) begin
        rdyCount++; rdyK = k; res = bus.data_result;
      end
      @(negedge clk);
    end
    checks++; if (rdyCount != 1) begin errors++; $display("FAIL ignored_start rdy count got %0d want 1", rdyCount); end
    checks++; if (rdyK != 32) begin errors++; $display("FAIL ignored_start rdy cycle got %0d want 32", rdyK); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL ignored_start result got %h want ffffffeb", res); end
  endtask

  task automatic test_reset_mid();
    obsT o;
    int  rdyCount = 0;
    int  busyCount = 0;
    doOp(1'b1, 1'b0, 32'h0001_0001, 32'h0001_0000, o);
    checks++; if (o.res !== 32'h0001_0000 || o.exc !== 1'b1) begin errors++; $display("FAIL pre_reset op got %h/%b want 00010000/1", o.res, o.exc); end
    @(negedge clk);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd7; bus.data_operandB = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.data_result !== 32'h0) begin errors++; $display("FAIL midreset result got %h want 0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL midreset exception got %b want 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midreset rdy/busy got %b/%b want 0/0", bus.data_resultRDY, bus.busy); end
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) rdyCount++;
      if (bus.busy === 1'b1) busyCount++;
      @(negedge clk);
    end
    checks++; if (rdyCount != 0 || busyCount != 0) begin errors++; $display("FAIL midreset aborted op got rdy %0d busy %0d want 0 0", rdyCount, busyCount); end
    doOp(1'b1, 1'b0, 32'd9, 32'd9, o);
    checks++; if (o.res !== 32'd81 || o.lat != 32) begin errors++; $display("FAIL post_reset op got %h lat %0d want 51 lat 32", o.res, o.lat); end
  endtask

  task automatic test_back_to_back();
    int          k1 = -1;
    int          gap = -1;
    logic [31:0] res1 = '0;
    logic [31:0] res2 = '0;
    logic        busyNext;
    @(negedge clk);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd12; bus.data_operandB = 32'd12;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) begin k1 = k; res1 = bus.data_result; break; end
      @(negedge clk);
    end
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'hFFFF_FFFB; bus.data_operandB = 32'd6;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    busyNext = bus.busy;
    for (int k = 1; k < 45; k++) begin
      if (bus.data_resultRDY === 1'b1) begin gap = k; res2 = bus.data_result; break; end
      @(negedge clk);
    end
    checks++; if (k1 != 32 || res1 !== 32'd144) begin errors++; $display("FAIL b2b first got %h lat %0d want 90 lat 32", res1, k1); end
    checks++; if (busyNext !== 1'b1) begin errors++; $display("FAIL b2b busy after done got %b want 1", busyNext); end
    checks++; if (gap != 33) begin errors++; $display("FAIL b2b rdy gap got %0d want 33", gap); end
    checks++; if (res2 !== 32'hFFFF_FFE2) begin errors++; $display("FAIL b2b second result got %h want ffffffe2", res2); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_simultaneous();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
